async_fifo_gray: RTL and testbench

// - Dual-clock FIFO that moves DATA_WIDTH-bit words from the wr_clk domain to the rd_clk domain.
// - Pointers cross domains as Gray code through 2-flop synchronisers. Flags are registered and conservative.
// - Adds per-domain fill levels, programmable almost-full/almost-empty, and overflow/underflow pulses.
// - Drop-in building block for CDC data paths. DEPTH must be a power of two.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/gray_sync.sv | 24 ++
 rtl/async_fifo_gray.sv | 162 ++++++++++++++++
 tb/tb_async_fifo_gray.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - Gray/binary conversion and address-width helpers for async_fifo_gray
package fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Callers zero-extend narrower pointers; the zero upper bits leave the low bits exact.
    function automatic gray_word_t gray2bin(input gray_word_t gray);
        gray_word_t bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-flop synchroniser for a Gray-coded pointer
module gray_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/async_fifo_gray.sv
// rtl/async_fifo_gray.sv - dual-clock FIFO with Gray pointer crossing, levels and flag pulses
module async_fifo_gray
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int AF_MARGIN   = 2,
    parameter int AE_MARGIN   = 2,
    parameter int SYNC_STAGES = 2,
    localparam int AW         = addr_width(DEPTH)
) (
    input  logic                  reset,
    input  logic                  wr_clk,
    input  logic                  rd_clk,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    output logic [AW:0]           wr_level,
    output logic                  wr_overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic [AW:0]           rd_level,
    output logic                  rd_underflow
);

    localparam int PW = AW + 1;

    // Async assert, synchronous release of the shared reset into each clock domain.
    logic [1:0] wr_rst_q;
    logic [1:0] rd_rst_q;
    logic       wr_rst;
    logic       rd_rst;

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            wr_rst_q <= 2'b11;
        end else begin
            wr_rst_q <= {wr_rst_q[0], 1'b0};
        end
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            rd_rst_q <= 2'b11;
        end else begin
            rd_rst_q <= {rd_rst_q[0], 1'b0};
        end
    end

    assign wr_rst = wr_rst_q[1];
    assign rd_rst = rd_rst_q[1];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW:0] wbin;
    logic [AW:0] wgray;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] wq_rgray;
    logic [AW:0] wq_rbin;
    logic [AW:0] wr_level_next;
    logic        wr_full_next;
    logic        wr_push;

    logic [AW:0] rbin;
    logic [AW:0] rgray;
    logic [AW:0] rbin_next;
    logic [AW:0] rgray_next;
    logic [AW:0] rq_wgray;
    logic [AW:0] rq_wbin;
    logic [AW:0] rd_level_next;
    logic        rd_empty_next;
    logic        rd_pop;

    gray_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_w2r (
        .clk    (rd_clk),
        .reset  (rd_rst),
        .d      (wgray),
        .q      (rq_wgray)
    );

    gray_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_r2w (
        .clk    (wr_clk),
        .reset  (wr_rst),
        .d      (rgray),
        .q      (wq_rgray)
    );

    assign wr_push       = wr_en && !wr_full;
    assign wbin_next     = wbin + {{AW{1'b0}}, wr_push};
    assign wgray_next    = PW'(bin2gray(gray_word_t'(wbin_next)));
    assign wq_rbin       = PW'(gray2bin(gray_word_t'(wq_rgray)));
    assign wr_level_next = wbin_next - wq_rbin;
    // Full when the writer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign wr_full_next  = (wgray_next == {~wq_rgray[AW:AW-1], wq_rgray[AW-2:0]});

    always_ff @(posedge wr_clk) begin
        if (wr_push) begin
            mem[wbin[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wbin           <= '0;
            wgray          <= '0;
            wr_full        <= 1'b0;
            wr_almost_full <= 1'b0;
            wr_level       <= '0;
            wr_overflow    <= 1'b0;
        end else begin
            wbin           <= wbin_next;
            wgray          <= wgray_next;
            wr_full        <= wr_full_next;
            wr_almost_full <= (wr_level_next >= PW'(DEPTH - AF_MARGIN));
            wr_level       <= wr_level_next;
            wr_overflow    <= wr_en && wr_full;
        end
    end

    assign rd_pop        = rd_en && !rd_empty;
    assign rbin_next     = rbin + {{AW{1'b0}}, rd_pop};
    assign rgray_next    = PW'(bin2gray(gray_word_t'(rbin_next)));
    assign rq_wbin       = PW'(gray2bin(gray_word_t'(rq_wgray)));
    assign rd_level_next = rq_wbin - rbin_next;
    assign rd_empty_next = (rgray_next == rq_wgray);

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rbin            <= '0;
            rgray           <= '0;
            rd_data         <= '0;
            rd_valid        <= 1'b0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            rd_level        <= '0;
            rd_underflow    <= 1'b0;
        end else begin
            rbin            <= rbin_next;
            rgray           <= rgray_next;
            if (rd_pop) begin
                rd_data <= mem[rbin[AW-1:0]];
            end
            rd_valid        <= rd_pop;
            rd_empty        <= rd_empty_next;
            rd_almost_empty <= (rd_level_next <= PW'(AE_MARGIN));
            rd_level        <= rd_level_next;
            rd_underflow    <= rd_en && rd_empty;
        end
    end

endmodule

// File: tb/tb_async_fifo_gray.sv
// tb/tb_async_fifo_gray.sv - self-checking bench for async_fifo_gray against a queue model
`timescale 1ns/100ps
module tb_async_fifo_gray;

    localparam int DW          = 8;
    localparam int DEPTH       = 16;
    localparam int AW          = 4;
    localparam int AF_MARGIN   = 2;
    localparam int AE_MARGIN   = 2;
    localparam int SYNC_STAGES = 2;

    logic          reset = 1'b0;
    logic          wr_clk = 1'b0;
    logic          rd_clk = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_full;
    logic          wr_almost_full;
    logic [AW:0]   wr_level;
    logic          wr_overflow;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_empty;
    logic          rd_almost_empty;
    logic [AW:0]   rd_level;
    logic          rd_underflow;

    real rd_half = 6.5;

    initial forever #5 wr_clk = ~wr_clk;
    initial forever #(rd_half) rd_clk = ~rd_clk;

    async_fifo_gray #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .AF_MARGIN   (AF_MARGIN),
        .AE_MARGIN   (AE_MARGIN),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .reset           (reset),
        .wr_clk          (wr_clk),
        .rd_clk          (rd_clk),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .wr_full         (wr_full),
        .wr_almost_full  (wr_almost_full),
        .wr_level        (wr_level),
        .wr_overflow     (wr_overflow),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_empty        (rd_empty),
        .rd_almost_empty (rd_almost_empty),
        .rd_level        (rd_level),
        .rd_underflow    (rd_underflow)
    );

    // Model: words accepted but not yet read, in order.
    logic [DW-1:0] q[$];
    logic          chk_en = 1'b0;
    logic          exp_of = 1'b0;
    logic          exp_uf = 1'b0;
    logic          exp_v  = 1'b0;
    logic [DW-1:0] exp_d  = '0;
    int            n_rx = 0;
    int            rd_edges = 0;
    int            n_ovf = 0;
    int            n_uf = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge rd_clk) rd_edges <= rd_edges + 1;

    always @(posedge wr_clk) begin
        if (!reset && chk_en) begin
            exp_of <= wr_en && wr_full;
            if (wr_en && !wr_full) q.push_back(wr_data);
        end else begin
            exp_of <= 1'b0;
        end
    end

    always @(posedge rd_clk) begin
        if (!reset && chk_en) begin
            exp_uf <= rd_en && rd_empty;
            exp_v  <= rd_en && !rd_empty;
            if (rd_en && !rd_empty) begin
                check("rd_accept_model_nonempty", q.size() != 0, 1);
                if (q.size() != 0) exp_d <= q.pop_front();
                n_rx <= n_rx + 1;
            end
        end else begin
            exp_uf <= 1'b0;
            exp_v  <= 1'b0;
            exp_d  <= '0;
        end
    end

    always @(negedge wr_clk) begin
        if (!reset && chk_en) begin
            if (wr_overflow) n_ovf++;
            check("wr_overflow", wr_overflow, exp_of);
            check("wr_full_vs_level", wr_full, wr_level == DEPTH);
            check("wr_almost_full_vs_level", wr_almost_full, wr_level >= DEPTH - AF_MARGIN);
            check("wr_level_bounds", (wr_level <= DEPTH) && (wr_level >= q.size()), 1);
        end
    end

    always @(negedge rd_clk) begin
        if (!reset && chk_en) begin
            if (rd_underflow) n_uf++;
            check("rd_valid", rd_valid, exp_v);
            check("rd_data", rd_data, exp_d);
            check("rd_underflow", rd_underflow, exp_uf);
            check("rd_empty_vs_level", rd_empty, rd_level == 0);
            check("rd_almost_empty_vs_level", rd_almost_empty, rd_level <= AE_MARGIN);
            check("rd_level_bounds", rd_level <= q.size(), 1);
        end
    end

    task automatic apply_reset();
        chk_en = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        reset  = 1'b1;
        q.delete();
        #1;
        check("rst_wr_full", wr_full, 0);
        check("rst_wr_almost_full", wr_almost_full, 0);
        check("rst_wr_level", wr_level, 0);
        check("rst_wr_overflow", wr_overflow, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_empty", rd_empty, 1);
        check("rst_rd_almost_empty", rd_almost_empty, 1);
        check("rst_rd_level", rd_level, 0);
        check("rst_rd_underflow", rd_underflow, 0);
        @(posedge wr_clk);
        @(negedge wr_clk);
        reset = 1'b0;
        repeat (4) @(negedge wr_clk);
        repeat (4) @(negedge rd_clk);
        chk_en = 1'b1;
    endtask

    task automatic wr_word(input logic [DW-1:0] d);
        @(negedge wr_clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge wr_clk);
        wr_en   = 1'b0;
    endtask

    task automatic rd_word();
        @(negedge rd_clk);
        rd_en = 1'b1;
        @(negedge rd_clk);
        rd_en = 1'b0;
    endtask

    task automatic wait_not_empty(input string name);
        int k;
        k = 0;
        while (rd_empty && k < 20) begin
            @(negedge rd_clk);
            k++;
        end
        check(name, rd_empty, 0);
    endtask

    task automatic run_traffic(input int n, input bit rnd);
        int base;
        base = n_rx;
        fork
            begin
                int sent;
                sent = 0;
                for (int c = 0; c < 40000 && sent < n; c++) begin
                    @(negedge wr_clk);
                    if (!wr_full && (!rnd || $urandom_range(0, 1) == 1)) begin
                        wr_en   = 1'b1;
                        wr_data = DW'($urandom);
                        sent++;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                @(negedge wr_clk);
                wr_en = 1'b0;
                check("traffic_sent", sent, n);
            end
            begin
                for (int c = 0; c < 60000 && (n_rx - base) < n; c++) begin
                    @(negedge rd_clk);
                    rd_en = rnd ? ($urandom_range(0, 1) == 1 && !rd_empty) : 1'b1;
                end
                rd_en = 1'b0;
                check("traffic_received", n_rx - base, n);
            end
        join
        repeat (6) @(negedge rd_clk);
        repeat (6) @(negedge wr_clk);
        check("traffic_drained_rd_empty", rd_empty, 1);
        check("traffic_drained_wr_level", wr_level, 0);
    endtask

    initial begin
        int e0;
        int ovf0;
        int uf0;
        #2;
        apply_reset();

        // Fill without reading.
        for (int i = 0; i < DEPTH; i++) begin
            wr_word(DW'(i));
            check("fill_wr_level", wr_level, i + 1);
            check("fill_wr_almost_full", wr_almost_full, (i + 1) >= 14);
            check("fill_wr_full", wr_full, i == DEPTH - 1);
        end
        wr_word(8'hAA);
        check("fill_overflow_pulse", wr_overflow, 1);
        check("fill_level_after_overflow", wr_level, 16);
        repeat (8) @(negedge rd_clk);
        check("fill_rd_level", rd_level, 16);
        check("fill_rd_almost_empty", rd_almost_empty, 0);

        // Drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            rd_word();
            check("drain_rd_valid", rd_valid, 1);
            check("drain_rd_data", rd_data, i);
            check("drain_rd_level", rd_level, DEPTH - 1 - i);
            check("drain_rd_almost_empty", rd_almost_empty, (DEPTH - 1 - i) <= 2);
        end
        check("drain_rd_empty", rd_empty, 1);
        rd_word();
        check("drain_underflow_pulse", rd_underflow, 1);
        check("drain_no_valid", rd_valid, 0);
        check("drain_data_held", rd_data, 8'h0F);
        repeat (6) @(negedge wr_clk);
        check("drain_wr_level", wr_level, 0);
        check("drain_wr_full", wr_full, 0);

        // Latency of a single word.
        @(negedge wr_clk);
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        @(posedge wr_clk);
        e0 = rd_edges;
        @(negedge wr_clk);
        wr_en = 1'b0;
        wait_not_empty("latency_rd_empty_drop");
        check("latency_within_sync_plus_one", (rd_edges - e0) <= SYNC_STAGES + 1, 1);
        rd_word();
        check("latency_rd_data", rd_data, 8'h5A);
        check("latency_rd_valid", rd_valid, 1);

        // Streaming across several pointer wraps.
        run_traffic(100, 1'b0);

        // Reset with data in flight.
        for (int i = 0; i < 9; i++) wr_word(DW'(8'h40 + i));
        repeat (6) @(negedge rd_clk);
        check("midop_rd_level", rd_level, 9);
        apply_reset();
        wr_word(8'h33);
        wait_not_empty("midop_rd_empty_drop");
        rd_word();
        check("midop_first_word", rd_data, 8'h33);

        // Clock-ratio sweep with flag-gated random traffic.
        ovf0 = n_ovf;
        uf0  = n_uf;
        rd_half = 1.5;
        run_traffic(200, 1'b1);
        rd_half = 20.0;
        run_traffic(200, 1'b1);
        check("sweep_no_overflow", n_ovf - ovf0, 0);
        check("sweep_no_underflow", n_uf - uf0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
